block_fetch_sched: RTL and testbench

- Frame-level scheduler for the 8x8 block buffer loader: walks a frame of BLK_COLS x BLK_ROWS blocks stored block-linear in SRAM.
- Per block: computes the SRAM base address, pulses the loader's start, and waits for its done.
- Manages two ping-pong buffer slots so block k+1 loads while the downstream engine consumes block k.
- Sits between the frame-level control and the loader / consumer pair.

---
 rtl/block_fetch_sched.sv | 168 ++++++++++++++++
 tb/tb_block_fetch_sched.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/block_fetch_sched.sv
// Frame-level scheduler for the 8x8 block loader: walks the frame block-linear,
// ping-ponging two buffer slots between the loader and the downstream consumer.
module block_fetch_sched #(
    parameter int AW        = 18,
    parameter int BLK_COLS  = 8,
    parameter int BLK_ROWS  = 8,
    parameter int IDXW      = 6,
    parameter int BASE_ADDR = 0,
    parameter int TIMEOUT   = 256
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            frame_start,
    output logic            frame_busy,
    output logic            frame_done,
    output logic            err_timeout,
    output logic            ld_start,
    output logic [AW-1:0]   ld_base,
    output logic            ld_buf_sel,
    input  logic            ld_done,
    output logic            blk_valid,
    output logic            blk_buf_sel,
    output logic [IDXW-1:0] blk_idx,
    input  logic            blk_ack
);

    localparam int NBLK = BLK_COLS * BLK_ROWS;
    localparam int CW   = IDXW + 1;
    localparam int TW   = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        F_IDLE,
        F_CHECK,
        F_ISSUE,
        F_WAIT,
        F_DRAIN
    } fstate_t;

    fstate_t         state_q, state_d;
    logic [CW-1:0]   fidx_q, fidx_d;
    logic [IDXW-1:0] cidx_q, cidx_d;
    logic            ls_q, ls_d;
    logic            ps_q, ps_d;
    logic [1:0]      slot_full_q, slot_full_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic            err_timeout_q, err_timeout_d;
    logic            ld_start_q, ld_start_d;
    logic [AW-1:0]   ld_base_q, ld_base_d;
    logic            ld_buf_sel_q, ld_buf_sel_d;

    logic            busy;
    logic            ack_ok;
    logic [AW-1:0]   base_calc;

    assign busy      = (state_q != F_IDLE);
    assign ack_ok    = busy & slot_full_q[ps_q] & blk_ack;
    // Blocks are 64 words each, stored back to back from BASE_ADDR.
    assign base_calc = AW'(BASE_ADDR) + AW'({fidx_q, 6'b000000});

    always_comb begin
        state_d       = state_q;
        fidx_d        = fidx_q;
        cidx_d        = cidx_q;
        ls_d          = ls_q;
        ps_d          = ps_q;
        slot_full_d   = slot_full_q;
        timer_d       = timer_q;
        err_timeout_d = err_timeout_q;
        ld_start_d    = 1'b0;
        ld_base_d     = ld_base_q;
        ld_buf_sel_d  = ld_buf_sel_q;

        // Consumer release is applied first so a same-cycle load completion
        // (always on the other slot) layers on top of it.
        if (ack_ok) begin
            slot_full_d[ps_q] = 1'b0;
            ps_d              = ~ps_q;
            cidx_d            = cidx_q + IDXW'(1);
        end

        case (state_q)
            F_IDLE: begin
                if (frame_start) begin
                    fidx_d        = '0;
                    cidx_d        = '0;
                    ls_d          = 1'b0;
                    ps_d          = 1'b0;
                    slot_full_d   = 2'b00;
                    err_timeout_d = 1'b0;
                    state_d       = F_CHECK;
                end
            end
            F_CHECK: begin
                if (fidx_q == CW'(NBLK)) begin
                    state_d = F_DRAIN;
                end else if (!slot_full_q[ls_q]) begin
                    state_d = F_ISSUE;
                end
            end
            F_ISSUE: begin
                ld_start_d   = 1'b1;
                ld_base_d    = base_calc;
                ld_buf_sel_d = ls_q;
                timer_d      = '0;
                state_d      = F_WAIT;
            end
            F_WAIT: begin
                if (ld_done) begin
                    slot_full_d[ls_q] = 1'b1;
                    ls_d              = ~ls_q;
                    fidx_d            = fidx_q + CW'(1);
                    state_d           = F_CHECK;
                end else if (timer_q == TW'(TIMEOUT - 1)) begin
                    err_timeout_d = 1'b1;
                    slot_full_d   = 2'b00;
                    state_d       = F_IDLE;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            F_DRAIN: begin
                if (slot_full_q == 2'b00) begin
                    state_d = F_IDLE;
                end
            end
            default: state_d = F_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q       <= F_IDLE;
            fidx_q        <= '0;
            cidx_q        <= '0;
            ls_q          <= 1'b0;
            ps_q          <= 1'b0;
            slot_full_q   <= 2'b00;
            timer_q       <= '0;
            err_timeout_q <= 1'b0;
            ld_start_q    <= 1'b0;
            ld_base_q     <= '0;
            ld_buf_sel_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            fidx_q        <= fidx_d;
            cidx_q        <= cidx_d;
            ls_q          <= ls_d;
            ps_q          <= ps_d;
            slot_full_q   <= slot_full_d;
            timer_q       <= timer_d;
            err_timeout_q <= err_timeout_d;
            ld_start_q    <= ld_start_d;
            ld_base_q     <= ld_base_d;
            ld_buf_sel_q  <= ld_buf_sel_d;
        end
    end

    assign frame_busy  = busy;
    assign frame_done  = (state_q == F_DRAIN) && (slot_full_q == 2'b00);
    assign err_timeout = err_timeout_q;
    assign ld_start    = ld_start_q;
    assign ld_base     = ld_base_q;
    assign ld_buf_sel  = ld_buf_sel_q;
    assign blk_valid   = busy & slot_full_q[ps_q];
    assign blk_buf_sel = ps_q;
    assign blk_idx     = cidx_q;

endmodule

// File: tb/tb_block_fetch_sched.sv
// Bench for block_fetch_sched: scenario table plus directed corner sequences,
// checked every cycle against a count-based model of loads, presentations and acks.
module tb_block_fetch_sched;

    localparam int AW      = 18;
    localparam int IDXW    = 6;
    localparam int NBLK    = 64;
    localparam int TIMEOUT = 256;
    localparam int BASE    = 0;

    logic            clock;
    logic            rst_n;
    logic            frame_start;
    logic            frame_busy;
    logic            frame_done;
    logic            err_timeout;
    logic            ld_start;
    logic [AW-1:0]   ld_base;
    logic            ld_buf_sel;
    logic            ld_done;
    logic            blk_valid;
    logic            blk_buf_sel;
    logic [IDXW-1:0] blk_idx;
    logic            blk_ack;

    block_fetch_sched dut (
        .clock       (clock),
        .reset       (rst_n),
        .frame_start (frame_start),
        .frame_busy  (frame_busy),
        .frame_done  (frame_done),
        .err_timeout (err_timeout),
        .ld_start    (ld_start),
        .ld_base     (ld_base),
        .ld_buf_sel  (ld_buf_sel),
        .ld_done     (ld_done),
        .blk_valid   (blk_valid),
        .blk_buf_sel (blk_buf_sel),
        .blk_idx     (blk_idx),
        .blk_ack     (blk_ack)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_chk = 0;
    int n_err = 0;

    // Test-sequence requests, turned into pin values once per cycle.
    bit rst_lo, fs_req, force_done, force_ack, chk_en;
    int ld_lat;       // 0: loader never answers on its own
    bit ld_rand;
    int ack_dly;      // <0: consumer never acks on its own
    bit ack_rand;
    int ld_cd, vcnt;

    // Reference model: counts of issued loads, completed loads and acks.
    bit m_busy, m_err, m_waiting;
    int m_loads, m_done, m_acks, m_wait;
    int fd_cnt, n_ldst, last_base, first_ack_loads;

    typedef struct {
        int lat;
        bit lrand;
        int ackd;
        bit arand;
        int exp_loads;
        int exp_fd;
        int exp_err;
        int exp_first;
        int exp_last;
    } scen_t;

    scen_t tbl[4];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_outputs();
        bit vexp;
        vexp = m_busy && (m_done > m_acks);
        chk("frame_busy", frame_busy, m_busy);
        chk("err_timeout", err_timeout, m_err);
        chk("blk_valid", blk_valid, vexp);
        if (blk_valid && vexp) begin
            chk("blk_idx", blk_idx, m_acks % NBLK);
            chk("blk_buf_sel", blk_buf_sel, m_acks % 2);
        end
        if (ld_start) begin
            chk("ld_start_in_frame", m_busy, 1);
            chk("ld_base", ld_base, (BASE + m_loads * 64) & ((1 << AW) - 1));
            chk("ld_buf_sel", ld_buf_sel, m_loads % 2);
            chk("ld_slot_free", (m_loads == m_done) && (m_loads - m_acks <= 1), 1);
        end
        if (frame_done) begin
            chk("frame_done_all", (m_acks == NBLK) && (m_done == NBLK), 1);
        end
    endtask

    task automatic model_step();
        bit vexp;
        if (!rst_n) begin
            m_busy = 0; m_err = 0; m_waiting = 0;
            m_loads = 0; m_done = 0; m_acks = 0; m_wait = 0;
            return;
        end
        if (frame_start && !m_busy) begin
            m_busy = 1; m_err = 0; m_waiting = 0;
            m_loads = 0; m_done = 0; m_acks = 0; m_wait = 0;
        end else if (m_busy) begin
            vexp = m_done > m_acks;
            if (ld_start) begin
                m_loads++;
                m_waiting = 1;
                m_wait = 0;
            end
            if (blk_ack && vexp) begin
                if (m_acks == 0) first_ack_loads = m_loads;
                m_acks++;
            end
            if (m_waiting) begin
                if (ld_done) begin
                    m_done++;
                    m_waiting = 0;
                end else if (m_wait == TIMEOUT - 1) begin
                    m_busy = 0;
                    m_err = 1;
                    m_waiting = 0;
                end else begin
                    m_wait++;
                end
            end
            if (frame_done) m_busy = 0;
        end
    endtask

    // One clock: compare outputs, choose the inputs for the next edge, advance the model.
    task automatic cycle();
        @(negedge clock);
        if (chk_en) check_outputs();
        if (ld_start) begin
            n_ldst++;
            last_base = int'(ld_base);
        end
        if (frame_done) fd_cnt++;
        rst_n = ~rst_lo;
        ld_done = 1'b0;
        if (ld_cd > 0) begin
            ld_cd--;
            if (ld_cd == 0) ld_done = 1'b1;
        end
        if (ld_start && ld_lat > 0) ld_cd = ld_rand ? int'($urandom_range(1, 20)) : ld_lat;
        if (force_done) ld_done = 1'b1;
        force_done = 0;
        if (ack_rand) blk_ack = ($urandom_range(0, 2) == 0);
        else blk_ack = (ack_dly >= 0) && blk_valid && (vcnt >= ack_dly);
        if (force_ack) blk_ack = 1'b1;
        force_ack = 0;
        if (!blk_valid || blk_ack) vcnt = 0;
        else vcnt++;
        frame_start = fs_req;
        fs_req = 0;
        if (!rst_n) begin
            ld_cd = 0;
            vcnt = 0;
        end
        model_step();
    endtask

    task automatic run_until_idle(input int max, input string name);
        int n = 0;
        while (frame_busy === 1'b1 && n < max) begin
            cycle();
            n++;
        end
        chk(name, frame_busy, 0);
    endtask

    task automatic wait_ldstart(input int max, input string name);
        int n = 0;
        do begin
            cycle();
            n++;
        end while (ld_start !== 1'b1 && n < max);
        chk(name, ld_start, 1);
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{70, 1'b0, 1,   1'b0, 64, 1, 0, 1,  4032};
        tbl[1] = '{3,  1'b0, 500, 1'b0, 64, 1, 0, 2,  4032};
        tbl[2] = '{0,  1'b0, 1,   1'b0, 1,  0, 1, -1, 0};
        tbl[3] = '{1,  1'b1, 0,   1'b1, 64, 1, 0, -1, 4032};

        rst_lo = 1; rst_n = 1'b0; frame_start = 1'b0; ld_done = 1'b0; blk_ack = 1'b0;
        fs_req = 0; force_done = 0; force_ack = 0; chk_en = 0;
        ld_lat = 0; ld_rand = 0; ack_dly = -1; ack_rand = 0; ld_cd = 0; vcnt = 0;
        fd_cnt = 0; n_ldst = 0; last_base = 0; first_ack_loads = -1;

        repeat (3) cycle();
        chk("rst_frame_busy", frame_busy, 0);
        chk("rst_frame_done", frame_done, 0);
        chk("rst_err_timeout", err_timeout, 0);
        chk("rst_ld_start", ld_start, 0);
        chk("rst_ld_base", ld_base, 0);
        chk("rst_ld_buf_sel", ld_buf_sel, 0);
        chk("rst_blk_valid", blk_valid, 0);
        chk("rst_blk_buf_sel", blk_buf_sel, 0);
        chk("rst_blk_idx", blk_idx, 0);
        rst_lo = 0;
        chk_en = 1;
        repeat (2) cycle();

        // Whole-frame scenarios.
        for (int r = 0; r < 4; r++) begin
            ld_lat = tbl[r].lat; ld_rand = tbl[r].lrand;
            ack_dly = tbl[r].ackd; ack_rand = tbl[r].arand;
            fd_cnt = 0; n_ldst = 0; last_base = -1; first_ack_loads = -1;
            fs_req = 1;
            cycle();
            cycle();
            chk("busy_on_start", frame_busy, 1);
            chk("err_cleared_on_start", err_timeout, 0);
            run_until_idle(40000, "frame_end_bound");
            repeat (2) cycle();
            chk("ld_start_count", n_ldst, tbl[r].exp_loads);
            chk("frame_done_pulses", fd_cnt, tbl[r].exp_fd);
            chk("err_timeout_final", err_timeout, tbl[r].exp_err);
            chk("last_ld_base", last_base, tbl[r].exp_last);
            if (tbl[r].exp_first >= 0)
                chk("loads_before_first_ack", first_ack_loads, tbl[r].exp_first);
        end

        // Ignored frame_start / stray ack, then simultaneous ld_done and ack.
        ld_lat = 0; ld_rand = 0; ack_dly = -1; ack_rand = 0;
        fd_cnt = 0;
        fs_req = 1;
        wait_ldstart(20, "seq_a_first_ld_start");
        fs_req = 1;
        force_ack = 1;
        repeat (3) cycle();
        chk("stray_busy", frame_busy, 1);
        chk("stray_blk_valid", blk_valid, 0);
        force_done = 1;
        cycle();
        cycle();
        chk("blk0_valid", blk_valid, 1);
        chk("blk0_idx", blk_idx, 0);
        wait_ldstart(20, "seq_a_second_ld_start");
        chk("blk1_ld_base", ld_base, 64);
        chk("blk1_ld_buf_sel", ld_buf_sel, 1);
        repeat (3) cycle();
        force_done = 1;
        force_ack = 1;
        cycle();
        cycle();
        chk("simul_blk_valid", blk_valid, 1);
        chk("simul_blk_idx", blk_idx, 1);
        chk("simul_blk_buf_sel", blk_buf_sel, 1);
        ld_lat = 4; ack_dly = 2;
        run_until_idle(20000, "seq_a_end_bound");
        cycle();
        chk("seq_a_frame_done", fd_cnt, 1);

        // Reset mid-frame after five completed loads.
        ld_lat = 6; ack_dly = 1;
        fs_req = 1;
        begin
            int n = 0;
            do begin
                cycle();
                n++;
            end while (m_done < 5 && n < 2000);
        end
        chk("reach_fidx5", m_done, 5);
        rst_lo = 1;
        cycle();
        rst_lo = 0;
        cycle();
        chk("mid_rst_frame_busy", frame_busy, 0);
        chk("mid_rst_frame_done", frame_done, 0);
        chk("mid_rst_ld_start", ld_start, 0);
        chk("mid_rst_ld_base", ld_base, 0);
        chk("mid_rst_ld_buf_sel", ld_buf_sel, 0);
        chk("mid_rst_blk_valid", blk_valid, 0);
        chk("mid_rst_blk_buf_sel", blk_buf_sel, 0);
        chk("mid_rst_blk_idx", blk_idx, 0);
        chk("mid_rst_err", err_timeout, 0);
        cycle();
        fd_cnt = 0;
        fs_req = 1;
        wait_ldstart(20, "restart_ld_start");
        chk("restart_ld_base", ld_base, BASE);
        chk("restart_ld_buf_sel", ld_buf_sel, 0);
        run_until_idle(20000, "restart_end_bound");
        cycle();
        chk("restart_frame_done", fd_cnt, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
